pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/addsub_pkg.sv | 13 +
 rtl/addsub_stage.sv | 14 +
 rtl/pipe_addsub.sv | 134 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared defaults and result-flag type for the pipelined adder/subtractor.
package addsub_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

endpackage

// File: rtl/addsub_stage.sv
// One SEG-bit slice of the carry chain: sum and carry-out for a single pipeline segment.
module addsub_stage #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic           o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract, one SEG-bit carry segment per stage, with
// valid/ready flow control whose bubbles collapse under backpressure.
module pipe_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SEG{1'b1}});

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH");
    end

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_vin;
    logic [STAGES-1:0] w_cin;
    logic [STAGES-1:0] w_cout;
    logic [WIDTH-1:0]  r_a     [STAGES];
    logic [WIDTH-1:0]  r_bp    [STAGES];
    logic [WIDTH-1:0]  r_y     [STAGES];
    logic              r_c     [STAGES];
    logic [WIDTH-1:0]  w_ain   [STAGES];
    logic [WIDTH-1:0]  w_bpin  [STAGES];
    logic [WIDTH-1:0]  w_yin   [STAGES];
    logic [WIDTH-1:0]  w_ynext [STAGES];
    logic [SEG-1:0]    w_sum   [STAGES];
    logic [WIDTH-1:0]  r_yout;
    flags_t            r_flags;
    flags_t            w_flags;
    logic              w_chain;

    // A stage may load when empty or when its successor is draining it.
    always_comb begin
        w_load  = '0;
        w_chain = ~r_valid[LAST] | out_ready;
        w_load[LAST] = w_chain;
        for (int k = LAST - 1; k >= 0; k--) begin
            w_chain   = ~r_valid[k] | w_chain;
            w_load[k] = w_chain;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_vin[k]  = in_valid;
            assign w_ain[k]  = a;
            assign w_bpin[k] = sub ? ~b : b;
            assign w_yin[k]  = '0;
            assign w_cin[k]  = sub;
        end else begin : g_next
            assign w_vin[k]  = r_valid[k-1];
            assign w_ain[k]  = r_a[k-1];
            assign w_bpin[k] = r_bp[k-1];
            assign w_yin[k]  = r_y[k-1];
            assign w_cin[k]  = r_c[k-1];
        end

        addsub_stage #(.SEG(SEG)) u_stage (
            .i_a    (w_ain[k][k*SEG +: SEG]),
            .i_b    (w_bpin[k][k*SEG +: SEG]),
            .i_cin  (w_cin[k]),
            .o_sum  (w_sum[k]),
            .o_cout (w_cout[k])
        );

        assign w_ynext[k] = (w_yin[k] & ~(SLICE_MASK << (k * SEG)))
                          | (WIDTH'(w_sum[k]) << (k * SEG));
    end

    // Flags need the full result, so they are formed as the last slice completes.
    always_comb begin
        w_flags      = '0;
        w_flags.cout = w_cout[LAST];
        w_flags.ovf  = (w_ain[LAST][WIDTH-1] == w_bpin[LAST][WIDTH-1])
                     && (w_ynext[LAST][WIDTH-1] != w_ain[LAST][WIDTH-1]);
        w_flags.zero = (w_ynext[LAST] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_yout  <= '0;
            r_flags <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_valid[k] <= w_vin[k];
                end
            end
            if (w_load[LAST]) begin
                r_yout  <= w_ynext[LAST];
                r_flags <= w_flags;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < LAST; k++) begin
            if (w_load[k]) begin
                r_a[k]  <= w_ain[k];
                r_bp[k] <= w_bpin[k];
                r_y[k]  <= w_ynext[k];
                r_c[k]  <= w_cout[k];
            end
        end
    end

    assign in_ready  = w_load[0];
    assign out_valid = r_valid[LAST];
    assign y         = r_yout;
    assign cout      = r_flags.cout;
    assign ovf       = r_flags.ovf;
    assign zero      = r_flags.zero;

endmodule
